// File: rtl/data_mem_unit_pkg.sv
// rtl/data_mem_unit_pkg.sv - shared encodings for the MEM-stage data memory responder
package data_mem_unit_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_ctrl_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/data_mem_unit_align.sv
// rtl/data_mem_unit_align.sv - byte-lane steering, load extension and misalignment detect
module data_mem_unit_align
    import data_mem_unit_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic              is_store,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wlanes,
    output logic [DATA_W-1:0] rfmt,
    output logic              misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rword[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be       = 4'b0000;
        wlanes   = wdata;
        rfmt     = '0;
        misalign = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be     = 4'b0001 << addr_lo;
                    wlanes = {4{wdata[7:0]}};
                end
                F3_H: begin
                    misalign = addr_lo[0];
                    wlanes   = {2{wdata[15:0]}};
                    if (!addr_lo[0])
                        be = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                F3_W: begin
                    misalign = |addr_lo;
                    if (addr_lo == 2'b00)
                        be = 4'b1111;
                end
                default: be = 4'b0000;
            endcase
        end else begin
            // Unknown load sizes behave as LW, including the word alignment rule.
            case (funct3)
                F3_B:  rfmt = {{24{byte_v[7]}}, byte_v};
                F3_BU: rfmt = {24'h0, byte_v};
                F3_H: begin
                    misalign = addr_lo[0];
                    rfmt     = addr_lo[0] ? '0 : {{16{half_v[15]}}, half_v};
                end
                F3_HU: begin
                    misalign = addr_lo[0];
                    rfmt     = addr_lo[0] ? '0 : {16'h0, half_v};
                end
                default: begin
                    misalign = |addr_lo;
                    rfmt     = (addr_lo == 2'b00) ? rword : '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - multi-cycle load/store responder with pipeline stall and MEM/WB select
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        memCtrl,
    input  logic [2:0]        memFunct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    output logic              memStall,
    output logic              select,
    output logic [DATA_W-1:0] dataFromRam,
    output logic              misalign
);

    // A single-cycle stall leaves no BUSY cycle, so the access uses the live request.
    localparam bit DIRECT = (LATENCY == 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q;
    logic [1:0]          op_q;
    logic [2:0]          f3_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mis_q;

    logic                req, do_access;
    logic [1:0]          acc_op;
    logic [2:0]          acc_f3;
    logic [ADDR_W+1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [ADDR_W-1:0]   widx;
    logic [DATA_W-1:0]   rword, wlanes, rfmt;
    logic [3:0]          be;
    logic                acc_mis;
    logic                addr_unused;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    assign addr_unused = ^addr[DATA_W-1:ADDR_W+2];
    assign req         = (state_q == ST_IDLE) && (memCtrl != MEM_NONE);

    assign acc_op    = (state_q == ST_IDLE) ? memCtrl                : op_q;
    assign acc_f3    = (state_q == ST_IDLE) ? memFunct3              : f3_q;
    assign acc_addr  = (state_q == ST_IDLE) ? addr[ADDR_W+1:0]       : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? writeData              : wdata_q;
    assign widx      = acc_addr[ADDR_W+1:2];
    assign rword     = mem[widx];

    data_mem_unit_align u_align (
        .funct3   (acc_f3),
        .addr_lo  (acc_addr[1:0]),
        .is_store (acc_op == MEM_WRITE),
        .wdata    (acc_wdata),
        .rword    (rword),
        .be       (be),
        .wlanes   (wlanes),
        .rfmt     (rfmt),
        .misalign (acc_mis)
    );

    always_comb begin
        state_d   = state_q;
        memStall  = 1'b0;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    memStall = 1'b1;
                    if (DIRECT) begin
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                memStall = 1'b1;
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= MEM_NONE;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req) begin
                op_q    <= memCtrl;
                f3_q    <= memFunct3;
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= writeData;
                cnt_q   <= 4'(LATENCY - 1);
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (do_access) begin
                mis_q <= acc_mis && ((acc_op == MEM_READ) || (acc_op == MEM_WRITE));
                if (acc_op == MEM_READ)
                    rdata_q <= rfmt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_access && (acc_op == MEM_WRITE)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[widx][b*8 +: 8] <= wlanes[b*8 +: 8];
            end
        end
    end

    assign select      = (state_q == ST_RESP) && (op_q == MEM_READ);
    assign misalign    = (state_q == ST_RESP) && mis_q;
    assign dataFromRam = rdata_q;

endmodule
